// File: rtl/reg_bus_reader_if.sv
// Request / response / register-bus bundle for reg_bus_reader.
// slave is the reader itself, master is whoever issues reads and owns the bus.
interface reg_bus_reader_if #(
    parameter int NREG = 4,
    parameter int AW   = 2
);
    logic            req_valid;
    logic [AW-1:0]   req_addr;
    logic            req_ready;
    logic [NREG-1:0] oe;
    logic [3:0]      bus_d;
    logic            rsp_valid;
    logic [3:0]      rsp_data;
    logic [AW-1:0]   rsp_addr;
    logic            rsp_err;
    logic            rsp_ready;

    modport slave (
        input  req_valid, req_addr, bus_d, rsp_ready,
        output req_ready, oe, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport master (
        output req_valid, req_addr, bus_d, rsp_ready,
        input  req_ready, oe, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/reg_bus_reader.sv
// Read-side controller for a shared 4-bit tristate register bus.
// Enables one register at a time (oe active low), waits SETTLE cycles,
// captures the bus and returns the value on a valid/ready response port.
// A one-cycle all-released GAP state follows every response as bus turnaround.
//
// state | meaning
// IDLE  | bus released, ready for a request
// DRIVE | oe[rsp_addr] low, counting settle cycles
// RESP  | bus released, response held until accepted
// GAP   | one released cycle before the next request
module reg_bus_reader #(
    parameter int NREG   = 4,
    parameter int SETTLE = 2,
    parameter int AW     = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    reg_bus_reader_if.slave      bus
);
    localparam int            CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(SETTLE - 1);
    localparam logic [AW:0]   NREG_W  = (AW + 1)'(NREG);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP, GAP} state_t;

    state_t          r_state;
    logic [NREG-1:0] r_oe;
    logic            r_rsp_valid;
    logic [3:0]      r_rsp_data;
    logic [AW-1:0]   r_rsp_addr;
    logic            r_rsp_err;
    logic [CW-1:0]   r_cnt;

    logic            w_req_ready;
    logic            w_in_range;
    logic [NREG-1:0] w_oe_sel;

    assign w_req_ready = (r_state == IDLE) & ~clr;
    assign w_in_range  = ({1'b0, bus.req_addr} < NREG_W);

    // Active-low one-hot enable pattern for the requested address.
    always_comb begin
        w_oe_sel = '1;
        for (int i = 0; i < NREG; i++) begin
            if (bus.req_addr == AW'(i)) begin
                w_oe_sel[i] = 1'b0;
            end
        end
    end

    // Sequencer with registered oe and response outputs; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= IDLE;
            r_oe        <= '1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 4'h0;
            r_rsp_addr  <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_oe <= '1;
                    if (bus.req_valid && w_req_ready) begin
                        r_rsp_addr <= bus.req_addr;
                        r_cnt      <= '0;
                        if (w_in_range) begin
                            r_oe    <= w_oe_sel;
                            r_state <= DRIVE;
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 4'h0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_END) begin
                        r_rsp_data  <= bus.bus_d;
                        r_rsp_err   <= 1'b0;
                        r_oe        <= '1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= GAP;
                    end
                end
                GAP: begin
                    r_oe    <= '1;
                    r_state <= IDLE;
                end
                default: begin
                    r_oe    <= '1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.oe        = r_oe;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_addr  = r_rsp_addr;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_reg_bus_reader.sv
// Directed bench for reg_bus_reader: an NREG=4 instance for normal reads and
// an NREG=3 instance for the out-of-range case. Responses are checked against
// a scoreboard filled when each request is accepted.
module tb_reg_bus_reader;
    logic clk = 1'b0;
    logic clr = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] d;
        logic [1:0] a;
        logic       e;
    } exp_t;
    exp_t sb[$];

    logic [3:0] regs [4] = '{4'h3, 4'h5, 4'hA, 4'hC};

    reg_bus_reader_if #(.NREG(4), .AW(2)) if0 ();
    reg_bus_reader_if #(.NREG(3), .AW(2)) if1 ();

    reg_bus_reader #(.NREG(4), .SETTLE(2), .AW(2)) u0 (.clk(clk), .clr(clr), .bus(if0.slave));
    reg_bus_reader #(.NREG(3), .SETTLE(2), .AW(2)) u1 (.clk(clk), .clr(clr), .bus(if1.slave));

    always #5 clk = ~clk;

    // Pulled-up bus; an enabled register drives its stored value.
    always_comb begin
        if0.bus_d = 4'hF;
        for (int i = 0; i < 4; i++) if (!if0.oe[i]) if0.bus_d = regs[i];
    end
    always_comb begin
        if1.bus_d = 4'hF;
        for (int i = 0; i < 3; i++) if (!if1.oe[i]) if1.bus_d = regs[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus safety and response scoreboard for the NREG=4 instance.
    int ones_run = 0;
    bit seen_en  = 1'b0;
    bit in_en    = 1'b0;
    always @(negedge clk) begin
        chk("onehot0", ($countones(~if0.oe) <= 1) ? 32'd1 : 32'd0, 32'd1);
        chk("onehot1", ($countones(~if1.oe) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (clr) begin
            ones_run = 0;
            seen_en  = 1'b0;
            in_en    = 1'b0;
        end else if (if0.oe != 4'hF) begin
            if (!in_en && seen_en) chk("gap_ge3", (ones_run >= 3) ? 32'd1 : 32'd0, 32'd1);
            in_en    = 1'b1;
            seen_en  = 1'b1;
            ones_run = 0;
        end else begin
            in_en = 1'b0;
            ones_run++;
        end
        if (!clr && if0.rsp_valid && if0.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", {28'd0, if0.rsp_data}, {28'd0, e.d});
                chk("rsp_addr", {30'd0, if0.rsp_addr}, {30'd0, e.a});
                chk("rsp_err",  {31'd0, if0.rsp_err},  {31'd0, e.e});
            end
        end
    end

    // Issue one read on u0; returns one step after the acceptance edge.
    task automatic rd0(input logic [1:0] a, input bit push);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if0.req_valid = 1'b1;
        if0.req_addr  = a;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (if0.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        if (push) sb.push_back('{regs[a], a, 1'b0});
    endtask

    // Count negedges after acceptance until rsp_valid shows.
    task automatic wait_valid0(output int lat);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if0.rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int lat;
        int n_low;
        int n_bad;
        int first;
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_low;
        int n_bad;
        int first;
        if0.req_valid = 1'b0; if0.req_addr = '0; if0.rsp_ready = 1'b1;
        if1.req_valid = 1'b0; if1.req_addr = '0; if1.rsp_ready = 1'b1;

        // Reset
        clr = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready_during_clr", {31'd0, if0.req_ready}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("rst_oe",        {28'd0, if0.oe},       32'hF);
        chk("rst_rsp_valid", {31'd0, if0.rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {28'd0, if0.rsp_data},  32'd0);
        chk("rst_req_ready", {31'd0, if0.req_ready}, 32'd1);

        // Basic read of register 2
        rd0(2'd2, 1'b1);
        n_low = 0; first = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if0.oe == 4'b1011) n_low++;
            if (if0.rsp_valid && first < 0) first = k;
        end
        chk("basic_oe_low_cycles", n_low, 32'd2);
        chk("basic_latency",       first, 32'd2);
        chk("basic_oe_released",   {28'd0, if0.oe}, 32'hF);

        // Back-to-back with a stalled first response
        if0.rsp_ready = 1'b0;
        rd0(2'd0, 1'b1);
        wait_valid0(lat);
        chk("bp_latency", lat, 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("bp_stall_data",  {28'd0, if0.rsp_data},  32'h3);
            chk("bp_stall_oe",    {28'd0, if0.oe},        32'hF);
            chk("bp_stall_valid", {31'd0, if0.rsp_valid}, 32'd1);
            chk("bp_stall_ready", {31'd0, if0.req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        if0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_gap_valid", {31'd0, if0.rsp_valid}, 32'd0);
        chk("bp_gap_ready", {31'd0, if0.req_ready}, 32'd0);
        chk("bp_gap_oe",    {28'd0, if0.oe},        32'hF);
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, if0.req_ready}, 32'd1);
        rd0(2'd3, 1'b1);
        wait_valid0(lat);
        chk("bp_second_data", {28'd0, if0.rsp_data}, 32'hC);
        @(negedge clk); @(negedge clk);

        // Out-of-range on the three-register instance
        @(posedge clk); #1;
        if1.req_valid = 1'b1;
        if1.req_addr  = 2'd3;
        @(negedge clk);
        chk("oor_req_ready", {31'd0, if1.req_ready}, 32'd1);
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        @(negedge clk);
        chk("oor_valid", {31'd0, if1.rsp_valid}, 32'd1);
        chk("oor_err",   {31'd0, if1.rsp_err},   32'd1);
        chk("oor_data",  {28'd0, if1.rsp_data},  32'd0);
        chk("oor_addr",  {30'd0, if1.rsp_addr},  32'd3);
        n_bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (if1.oe != 3'b111) n_bad++;
            @(negedge clk);
        end
        chk("oor_no_oe", n_bad, 32'd0);

        // Reset in the first DRIVE cycle
        rd0(2'd2, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        chk("mid_req_ready_clr", {31'd0, if0.req_ready}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("mid_oe_released", {28'd0, if0.oe}, 32'hF);
        n_bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (if0.rsp_valid) n_bad++;
            @(negedge clk);
        end
        chk("mid_no_valid", n_bad, 32'd0);
        rd0(2'd1, 1'b1);
        wait_valid0(lat);
        chk("mid_next_latency", lat, 32'd2);
        chk("mid_next_data", {28'd0, if0.rsp_data}, 32'h5);
        @(negedge clk); @(negedge clk);

        // Address change after acceptance has no effect
        rd0(2'd1, 1'b1);
        if0.req_addr = 2'd3;
        n_low = 0; n_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (if0.oe == 4'b1101) n_low++;
            if (if0.oe == 4'b0111) n_bad++;
        end
        chk("ign_oe_accepted", n_low, 32'd2);
        chk("ign_oe_other",    n_bad, 32'd0);
        chk("ign_rsp_addr", {30'd0, if0.rsp_addr}, 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bus_reader.md
# reg_bus_reader

Read-side controller for the shared 4-bit tristate register bus. The storage registers on this bus float their outputs while their `oe` input is high, and drive `q` onto the bus while `oe` is low. This block serves single-register read requests. For each request it drives exactly one `oe` low, waits a fixed settle time, captures the bus and returns the value over a valid/ready response port. It guarantees no two registers are ever enabled together, with a one-cycle all-released gap between reads.

## Interface
Parameters:
- `NREG`, default 4: number of registers on the bus; must be ≥ 2.
- `SETTLE`, default 2: cycles `oe` is held low before capture; must be ≥ 1.
- `AW`, default 2: address width; must satisfy `2**AW >= NREG`.

Ports:
- `clk` (in, 1): single clock; all logic is on the rising edge.
- `clr` (in, 1): reset; synchronous, active-high.
- `req_valid` (in, 1): read request present.
- `req_addr` (in, AW): index of the register to read.
- `req_ready` (out, 1): block can accept a request.
- `oe` (out, NREG): per-register output enable. A 1 releases (tristates) that register; a 0 enables it. At most one bit is 0 at any time.
- `bus_d` (in, 4): shared tristate bus.
- `rsp_valid` (out, 1): response present.
- `rsp_data` (out, 4): captured value.
- `rsp_addr` (out, AW): address of this response.
- `rsp_err` (out, 1): the address was out of range (`req_addr >= NREG`).
- `rsp_ready` (in, 1): consumer accepts the response.

## Operation
- State machine with four states: IDLE, DRIVE, RESP, GAP.
- `req_ready` equals (state == IDLE) & ~`clr`; it is combinational.
- **IDLE**
  - Idles with `oe` all ones.
  - On `req_valid & req_ready`, latch `req_addr` into `rsp_addr` and clear `cnt`.
  - If `req_addr < NREG`, go to DRIVE.
  - Otherwise go to RESP with `rsp_err` = 1 and `rsp_data` = 0. No `oe` bit is touched.
- **DRIVE**
  - `oe[rsp_addr]` = 0; all other bits = 1.
  - `cnt` increments each cycle.
  - At the edge where `cnt == SETTLE-1`:
    - `rsp_data` ← `bus_d` and `rsp_err` ← 0.
    - `oe` ← all ones.
    - State goes to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_data`, `rsp_addr` and `rsp_err` hold stable until the handshake.
  - On `rsp_valid & rsp_ready`, go to GAP.
- **GAP**
  - One cycle with `oe` all ones and `rsp_valid` = 0, then IDLE.
  - This is the bus turnaround guard.
- `oe` is a registered output and never glitches; it changes only on clock edges.
- `cnt` is sized to hold `SETTLE-1`.
- `req_addr` is sampled only at acceptance. Later changes to it have no effect.
- **Reset.** `clr` takes priority over every transition. The state after the edge is:
  - state = IDLE
  - `oe` = all ones
  - `rsp_valid` = 0
  - `rsp_data` = 0
  - `rsp_addr` = 0
  - `rsp_err` = 0
  - `cnt` = 0
- **Reset mid-operation.** A `clr` during DRIVE releases `oe` at that edge and discards the capture. A `clr` during RESP drops the pending response without a handshake.

## Timing
- Acceptance edge E0. `oe[a]` is low for exactly `SETTLE` cycles, starting after E0.
- `bus_d` is sampled at edge E`SETTLE`, the last edge with `oe[a]` low.
- `rsp_valid` rises after edge E`SETTLE`. Read latency is therefore `SETTLE` cycles from acceptance.
- Out-of-range requests have `rsp_valid` high after E0+1 cycle, i.e. 1 cycle of latency.
- `oe` returns to all ones on the same edge that raises `rsp_valid`. The bus is released while the response waits.
- Back-to-back reads with `rsp_ready` tied high take a minimum period of `SETTLE`+3 cycles: 1 IDLE, `SETTLE` DRIVE, 1 RESP, 1 GAP.
- Consecutive enables of different registers are separated by at least 3 all-ones cycles.
- `rsp_ready` low stalls in RESP indefinitely with outputs frozen. `req_ready` stays 0 during the stall.

## Test plan
- **Reset.** Drive `clr` = 1 for 2 cycles, then release. Required after release: `oe` = 4'b1111, `rsp_valid` = 0, `rsp_data` = 0, and `req_ready` = 1 in the first cycle after `clr` falls.
- **Basic read.** NREG = 4, SETTLE = 2. Model registers with pullups and let register 2 drive 4'hA when its `oe` is low. Request addr 2 with `rsp_ready` = 1. Required:
  - `oe` = 4'b1011 for exactly 2 cycles.
  - `rsp_valid` high 2 cycles after acceptance, with `rsp_data` = 4'hA, `rsp_addr` = 2 and `rsp_err` = 0.
  - `oe` back to 4'b1111.
- **Back-to-back reads with backpressure.**
  - Sequence: read addr 0 (value 4'h3), then addr 3 (value 4'hC), holding `rsp_ready` = 0 for 4 cycles on the first response.
  - Required: `rsp_data` stays 4'h3 for all stall cycles, and `oe` stays 4'b1111 throughout.
  - Required: never more than one `oe` bit is 0, and a 1-cycle GAP precedes the second enable.
  - Required: the second response returns 4'hC.
- **Out-of-range address.** NREG = 3 with addr 3. Required: no `oe` bit goes low, and after 1 cycle `rsp_err` = 1 and `rsp_data` = 0.
- **Reset mid-read.** Assert `clr` in the first DRIVE cycle. Required: `oe` = all ones after that edge, no `rsp_valid` pulse, and the next read of addr 1 completes normally.
- **Ignored address changes.** Change `req_addr` after acceptance. Required: the enabled `oe` bit and `rsp_addr` match the accepted address.
